// File: rtl/synth_pkg.sv
// Shared types for the key-event path: note width and the queued event record.
package synth_pkg;

  localparam int NOTE_W = 7;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
  } key_evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO of key events; head is presented combinationally on pop_data.
module evt_fifo
  import synth_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  key_evt_t      push_data,
  input  logic          pop,
  output key_evt_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + LW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - LW'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Converts debounced key levels into queued note-on/off events and tracks a
// last-note-priority held note from the events the consumer has taken.
module key_event_encoder
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = 8,
  parameter int BASE_NOTE  = 60,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_clean,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [NOTE_W-1:0]             evt_note,
  output logic                          evt_on,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [NOTE_W-1:0]             active_note,
  output logic                          any_key_down
);

  if (BASE_NOTE + NUM_KEYS - 1 > 127) begin : g_note_range_check
    $error("key_event_encoder: BASE_NOTE+NUM_KEYS-1 exceeds 127");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("key_event_encoder: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] pend_v;
  logic [NUM_KEYS-1:0] pend_on;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] key_edge;
  logic [NUM_KEYS-1:0] sel_oh;
  logic [NUM_KEYS-1:0] v_mid;
  logic [NUM_KEYS-1:0] take_new;
  logic [NUM_KEYS-1:0] pend_v_n;
  logic [NUM_KEYS-1:0] pend_on_n;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] held_n;
  logic [NOTE_W-1:0]   sel_note;
  logic [NOTE_W-1:0]   active_n;
  logic                sel_found;
  logic                sel_on;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  key_evt_t            push_evt;
  key_evt_t            head_evt;

  assign rise     = key_clean & ~key_prev;
  assign fall     = ~key_clean & key_prev;
  assign key_edge = rise | fall;

  // Lowest-index pending key wins the single push slot.
  always_comb begin
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_note  = '0;
    sel_on    = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (pend_v[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_note  = NOTE_W'(BASE_NOTE + i);
        sel_on    = pend_on[i];
      end
    end
  end

  assign pop      = evt_valid & evt_ready;
  assign push     = sel_found & (~fifo_full | pop);
  assign push_evt = '{on: sel_on, note: sel_note};

  // Clear the pushed entry first, then fold in this cycle's edges: an edge on an
  // idle entry arms it with the new kind, an edge on an armed entry cancels the pair.
  always_comb begin
    v_mid     = pend_v & ~(push ? sel_oh : '0);
    take_new  = key_edge & ~v_mid;
    pend_v_n  = v_mid ^ key_edge;
    pend_on_n = (take_new & rise) | (~take_new & pend_on);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev <= '0;
      pend_v   <= '0;
      pend_on  <= '0;
    end else begin
      key_prev <= key_clean;
      pend_v   <= pend_v_n;
      pend_on  <= pend_on_n;
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_note  = head_evt.note;
  assign evt_on    = head_evt.on;

  // Releasing the current note falls back to the highest-index key still held.
  always_comb begin
    held_n   = held;
    active_n = active_note;
    if (pop) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (head_evt.note == NOTE_W'(BASE_NOTE + i)) begin
          held_n[i] = head_evt.on;
        end
      end
      if (head_evt.on) begin
        active_n = head_evt.note;
      end else if (head_evt.note == active_note) begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
          if (held_n[i]) begin
            active_n = NOTE_W'(BASE_NOTE + i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held         <= '0;
      active_note  <= '0;
      any_key_down <= 1'b0;
    end else begin
      held         <= held_n;
      active_note  <= active_n;
      any_key_down <= |held_n;
    end
  end

endmodule
